// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment module: frame-coherent capture, inter-digit blanking, hex decode.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN suppresses leading zero digits at capture.
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] display,
    input  logic [7:0]  displayEnable,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        o_dbg_state
);

    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t          r_state;
    logic [2:0]      r_idx;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_snap_data;
    logic [7:0]      r_snap_en;
    logic [7:0]      r_an;
    logic [6:0]      r_seg;

    logic [7:0]      w_cap_en;
    logic [31:0]     w_src_data;
    logic [7:0]      w_src_en;
    logic [3:0]      w_nib;
    logic            w_lit;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [7:0] w_lz;
    logic       w_zero_run;

    // Walk down from the top digit; a digit is blanked while everything above it is zero too.
    always_comb begin
        w_lz       = 8'h00;
        w_zero_run = 1'b1;
        for (int d = 7; d >= 1; d--) begin
            w_zero_run = w_zero_run && (display[4*d +: 4] == 4'h0);
            w_lz[d]    = w_zero_run;
        end
    end

    assign w_cap_en = displayEnable & ~w_lz;
`else
    assign w_cap_en = displayEnable;
`endif

    // Digit 0 decodes straight from the values being captured on this edge.
    assign w_src_data = (r_idx == 3'd0) ? display  : r_snap_data;
    assign w_src_en   = (r_idx == 3'd0) ? w_cap_en : r_snap_en;
    assign w_nib      = w_src_data[{r_idx, 2'b00} +: 4];
    assign w_lit      = w_src_en[r_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= BLANK;
            r_idx       <= 3'd0;
            r_cnt       <= '0;
            r_snap_data <= 32'h0;
            r_snap_en   <= 8'h00;
            r_an        <= 8'hFF;
            r_seg       <= 7'h7F;
        end else begin
            case (r_state)
                BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        r_cnt   <= '0;
                        r_state <= SHOW;
                        if (r_idx == 3'd0) begin
                            r_snap_data <= display;
                            r_snap_en   <= w_cap_en;
                        end
                        r_an  <= w_lit ? ~(8'b1 << r_idx) : 8'hFF;
                        r_seg <= w_lit ? hex_to_seg(w_nib) : 7'h7F;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        r_cnt   <= '0;
                        r_state <= BLANK;
                        r_an    <= 8'hFF;
                        r_seg   <= 7'h7F;
                        r_idx   <= r_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= BLANK;
            endcase
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = 1'b1;
    assign o_dbg_state = r_state;

endmodule
